// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one one-shot 64-bit timer among NUM_REQ requesters, granting round-robin.
// Optional macro TIMER_ARB_IRQ_EN adds sticky per-requester expiry status and a masked interrupt.
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*64-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     cancel,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     expired,
  output logic                   busy,
  output logic [PTR_W-1:0]       owner,
  output logic [63:0]            tmr_cmp_value,
  output logic                   tmr_start,
  output logic                   tmr_en,
  output logic                   tmr_int_en,
  output logic                   tmr_auto_reload,
  input  logic                   tmr_done
`ifdef TIMER_ARB_IRQ_EN
  ,
  output logic [NUM_REQ-1:0]     irq_status,
  input  logic [NUM_REQ-1:0]     irq_clr,
  output logic                   irq,
  input  logic [NUM_REQ-1:0]     irq_mask
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ZERO
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_REQ - 1);

  state_t               r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]     r_owner, w_owner_nxt, w_owner_inc;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]   r_expired, w_expired_nxt;
  logic [63:0]          r_cmp, w_cmp_nxt;
  logic                 r_start, w_start_nxt;
  logic                 r_en, w_en_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [NUM_REQ-1:0]   w_cand;
  logic [PTR_W-1:0]     w_sel;
  logic                 w_sel_vld;
  logic [63:0]          w_sel_period;
  int                   w_idx;

  // A requester cancelling in the same cycle it requests is not eligible.
  assign w_cand       = req & ~cancel;
  assign w_sel_period = req_period[64*w_sel +: 64];
  assign w_owner_inc  = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);

  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_sel_vld && w_cand[w_idx]) begin
        w_sel     = PTR_W'(w_idx);
        w_sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cmp_nxt     = r_cmp;
    w_grant_nxt   = '0;
    w_expired_nxt = '0;
    w_start_nxt   = 1'b0;
    w_en_nxt      = r_en;
    w_busy_nxt    = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_grant_nxt = ONE_HOT_0 << w_sel;
          w_owner_nxt = w_sel;
          w_cmp_nxt   = w_sel_period;
          w_busy_nxt  = 1'b1;
          if (w_sel_period != 64'd0) begin
            w_start_nxt = 1'b1;
            w_en_nxt    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_ZERO;
          end
        end
      end
      S_RUN: begin
        // Done takes priority over a simultaneous cancel so a finished delay is never lost.
        if (tmr_done || cancel[r_owner]) begin
          w_expired_nxt = tmr_done ? (ONE_HOT_0 << r_owner) : '0;
          w_en_nxt      = 1'b0;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = w_owner_inc;
          w_state_nxt   = S_IDLE;
        end
      end
      S_ZERO: begin
        w_expired_nxt = ONE_HOT_0 << r_owner;
        w_busy_nxt    = 1'b0;
        w_ptr_nxt     = w_owner_inc;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cmp     <= '0;
      r_grant   <= '0;
      r_expired <= '0;
      r_start   <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cmp     <= w_cmp_nxt;
      r_grant   <= w_grant_nxt;
      r_expired <= w_expired_nxt;
      r_start   <= w_start_nxt;
      r_en      <= w_en_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign grant           = r_grant;
  assign expired         = r_expired;
  assign busy            = r_busy;
  assign owner           = r_owner;
  assign tmr_cmp_value   = r_cmp;
  assign tmr_start       = r_start;
  assign tmr_en          = r_en;
  assign tmr_int_en      = 1'b0;
  assign tmr_auto_reload = 1'b0;

`ifdef TIMER_ARB_IRQ_EN
  logic [NUM_REQ-1:0] r_irq_status;

  // Set dominates clear so an expiry coinciding with a clear is not dropped.
  always_ff @(posedge clk) begin
    if (rst) r_irq_status <= '0;
    else     r_irq_status <= (r_irq_status & ~irq_clr) | r_expired;
  end

  assign irq_status = r_irq_status;
  assign irq        = |(r_irq_status & irq_mask);
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: transaction-level model plus a simple one-shot timer model.
module tb_timer_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, cancel;
  logic [N*64-1:0] req_period;
  logic            tmr_done;
  logic [N-1:0]    grant, expired;
  logic            busy;
  logic [1:0]      owner;
  logic [63:0]     tmr_cmp_value;
  logic            tmr_start, tmr_en, tmr_int_en, tmr_auto_reload;
`ifdef TIMER_ARB_IRQ_EN
  logic [N-1:0]    irq_status, irq_clr, irq_mask;
  logic            irq;
`endif

  always #5 clk = ~clk;

  timer_arbiter #(.NUM_REQ(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_period      (req_period),
    .cancel          (cancel),
    .grant           (grant),
    .expired         (expired),
    .busy            (busy),
    .owner           (owner),
    .tmr_cmp_value   (tmr_cmp_value),
    .tmr_start       (tmr_start),
    .tmr_en          (tmr_en),
    .tmr_int_en      (tmr_int_en),
    .tmr_auto_reload (tmr_auto_reload),
    .tmr_done        (tmr_done)
`ifdef TIMER_ARB_IRQ_EN
    ,
    .irq_status      (irq_status),
    .irq_clr         (irq_clr),
    .irq             (irq),
    .irq_mask        (irq_mask)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: which requester owns the timer, whether its delay is timed or zero, and the rotation start.
  int           m_ptr, m_owner, m_phase;   // phase: 0 free, 1 timed delay, 2 zero delay
  logic [N-1:0] e_grant, e_expired;
  logic         e_busy, e_start, e_en;
  logic [63:0]  e_cmp;
  logic [N-1:0] e_status;
  int           t_cnt;
  logic         inj_done;

  int g_cyc[$], g_idx[$], x_cyc[$];

  task automatic set_period(input int i, input int p);
    req_period[64*i +: 64] = 64'(p);
  endtask

  task automatic release_timer();
    e_en    = 1'b0;
    e_busy  = 1'b0;
    m_ptr   = (m_owner + 1) % N;
    m_phase = 0;
    t_cnt   = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] prev_exp;
    int sel;
    prev_exp  = e_expired;
    e_grant   = '0;
    e_expired = '0;
    e_start   = 1'b0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; t_cnt = 0;
      e_cmp = '0; e_en = 1'b0; e_busy = 1'b0; e_status = '0;
    end else begin
`ifdef TIMER_ARB_IRQ_EN
      e_status = (e_status & ~irq_clr) | prev_exp;
`endif
      if (m_phase == 0) begin
        sel = -1;
        for (int k = 0; k < N; k++)
          if (sel < 0 && req[(m_ptr + k) % N] && !cancel[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        if (sel >= 0) begin
          e_grant[sel] = 1'b1;
          m_owner      = sel;
          e_cmp        = req_period[64*sel +: 64];
          e_busy       = 1'b1;
          if (e_cmp != 0) begin
            e_start = 1'b1;
            e_en    = 1'b1;
            m_phase = 1;
            t_cnt   = int'(e_cmp) + 1;
          end else begin
            m_phase = 2;
          end
        end
      end else if (m_phase == 1) begin
        if (tmr_done) begin
          e_expired[m_owner] = 1'b1;
          release_timer();
        end else if (cancel[m_owner]) begin
          release_timer();
        end
      end else begin
        e_expired[m_owner] = 1'b1;
        release_timer();
      end
    end
  endtask

  // One clock: drive timer done, advance the model, then land just after the next falling edge.
  task automatic tick();
    if (t_cnt > 0) begin
      t_cnt--;
      tmr_done = (t_cnt == 0);
    end else begin
      tmr_done = inj_done;
    end
    model_step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("grant",       64'(grant),         64'(e_grant));
      check("expired",     64'(expired),       64'(e_expired));
      check("busy",        64'(busy),          64'(e_busy));
      check("owner",       64'(owner),         64'(m_owner));
      check("cmp_value",   tmr_cmp_value,      e_cmp);
      check("tmr_start",   64'(tmr_start),     64'(e_start));
      check("tmr_en",      64'(tmr_en),        64'(e_en));
      check("tmr_int_en",  64'(tmr_int_en),    64'd0);
      check("auto_reload", 64'(tmr_auto_reload), 64'd0);
      check("grant_onehot",   64'($onehot0(grant)),   64'd1);
      check("expired_onehot", 64'($onehot0(expired)), 64'd1);
      check("grant_vs_expired", 64'((grant != 0) && (expired != 0)), 64'd0);
`ifdef TIMER_ARB_IRQ_EN
      check("irq_status", 64'(irq_status), 64'(e_status));
      check("irq",        64'(irq),        64'(|(e_status & irq_mask)));
`endif
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          g_cyc.push_back(cyc);
          g_idx.push_back(i);
        end
        if (expired[i]) x_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; cancel = '0; req_period = '0; tmr_done = 1'b0; inj_done = 1'b0;
    m_ptr = 0; m_owner = 0; m_phase = 0; t_cnt = 0;
    e_grant = '0; e_expired = '0; e_busy = 1'b0; e_start = 1'b0; e_en = 1'b0; e_cmp = '0; e_status = '0;
`ifdef TIMER_ARB_IRQ_EN
    irq_clr = '0; irq_mask = '0;
`endif
    tick(); tick();
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_cmp",   tmr_cmp_value, 64'd0);

    // Single requester, period 10: done 10 cycles after start, expiry the cycle after.
    rst = 1'b0; set_period(0, 10); req = 4'b0001;
    tick();
    check("t1_grant", 64'(grant), 64'h1);
    check("t1_cmp",   tmr_cmp_value, 64'd10);
    check("t1_start", 64'(tmr_start), 64'd1);
    req = '0;
    repeat (10) tick();
    check("t1_early_exp", 64'(expired), 64'd0);
    check("t1_busy_hold", 64'(busy), 64'd1);
    tick();
    check("t1_exp",      64'(expired), 64'h1);
    check("t1_busy_off", 64'(busy), 64'd0);
    tick();

    // All four requesting with period 5: strict rotation, regrant one cycle after expiry.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_period(i, 5);
    g_cyc.delete(); g_idx.delete(); x_cyc.delete();
    req = 4'b1111;
    repeat (40) tick();
    req = '0;
    repeat (10) tick();
    check("t2_grant_count", 64'(g_idx.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (g_idx.size() > i) check("t2_order", 64'(g_idx[i]), 64'(i % N));
      if (i > 0 && g_cyc.size() > i && x_cyc.size() >= i)
        check("t2_regrant_gap", 64'(g_cyc[i] - x_cyc[i-1]), 64'd1);
    end

    // Zero period: grant then expiry next cycle, timer never started.
    rst = 1'b1; tick(); rst = 1'b0;
    set_period(2, 0); req = 4'b0100;
    tick();
    check("t3_grant", 64'(grant), 64'h4);
    check("t3_start", 64'(tmr_start), 64'd0);
    req = '0;
    tick();
    check("t3_exp", 64'(expired), 64'h4);
    tick();

    // Cancel of the owner mid-delay; pending req3 is granted next.
    rst = 1'b1; tick(); rst = 1'b0;
    set_period(1, 100); req = 4'b0010;
    tick();
    check("t4_grant1", 64'(grant), 64'h2);
    req = 4'b1000; set_period(3, 7);
    repeat (19) tick();
    cancel = 4'b0010;
    tick();
    check("t4_en_off", 64'(tmr_en), 64'd0);
    check("t4_no_exp", 64'(expired), 64'd0);
    cancel = '0;
    tick();
    check("t4_grant3", 64'(grant), 64'h8);
    req = '0;
    repeat (10) tick();

    // Cancel and done together: done wins.
    rst = 1'b1; tick(); rst = 1'b0;
    set_period(0, 3); req = 4'b0001;
    tick();
    req = '0;
    repeat (3) tick();
    cancel = 4'b0001;
    tick();
    check("t5_done_wins", 64'(expired), 64'h1);
    cancel = '0;
    tick();

    // Reset during a timed delay.
    set_period(1, 50); req = 4'b0010;
    tick();
    req = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t5_rst_en",   64'(tmr_en), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_exp",  64'(expired), 64'd0);
    rst = 1'b0;
    tick();

`ifdef TIMER_ARB_IRQ_EN
    irq_mask = 4'b0001; set_period(0, 2); req = 4'b0001;
    tick();
    req = '0;
    repeat (3) tick();
    check("t6_exp0", 64'(expired), 64'h1);
    tick();
    check("t6_status", 64'(irq_status), 64'h1);
    check("t6_irq",    64'(irq), 64'd1);
    req = 4'b0001;
    tick();
    req = '0;
    repeat (3) tick();
    irq_clr = 4'b0001;
    tick();
    check("t6_set_wins", 64'(irq_status), 64'h1);
    tick();
    check("t6_cleared", 64'(irq_status), 64'h0);
    check("t6_irq_off", 64'(irq), 64'd0);
    irq_clr = '0;
`endif

    // Randomized traffic: requests held until granted, sporadic cancels, stray dones, resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_period(i, int'($urandom_range(0, 8)));
        end
        cancel[i] = ($urandom_range(0, 15) == 0);
      end
      inj_done = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 499) == 0);
`ifdef TIMER_ARB_IRQ_EN
      irq_clr  = N'($urandom);
      irq_mask = N'($urandom);
`endif
      tick();
      for (int i = 0; i < N; i++) if (e_grant[i]) req[i] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one timer instance (64-bit compare, single done) between NUM_REQ requesters that each need a one-shot delay.
- Picks one requester round-robin, loads its period into the timer's compare value and starts the timer.
- Waits for the timer's done, then returns a one-cycle expiry pulse to that requester.
- Sits between the timer and the software-visible channel registers. The timer runs in one-shot mode with its own interrupt disabled.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- PTR_W, $clog2(NUM_REQ), width of the round-robin pointer and owner index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester arm request; level, held until grant
- req_period  in  NUM_REQ*64  flat period bus; slice i = [64*i+63 : 64*i]
- cancel  in  NUM_REQ  per-requester abort, level
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted
- expired  out  NUM_REQ  one-hot, one-cycle pulse when the owner's delay elapses
- busy  out  1  high while the timer is owned
- owner  out  PTR_W  index of the current/last owner
- tmr_cmp_value  out  64  compare value to the timer
- tmr_start  out  1  one-cycle start pulse to the timer
- tmr_en  out  1  timer enable
- tmr_int_en  out  1  tied 0
- tmr_auto_reload  out  1  tied 0
- tmr_done  in  1  timer compare-match indication

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, owner 0. A reset mid-RUN drops tmr_en the next edge and raises no expired pulse.
- States: IDLE, RUN, ZERO.
- IDLE:
  - When req != 0, select the first set bit searching upward from the pointer, wrapping at NUM_REQ.
  - Next edge: grant[sel]=1, owner=sel, tmr_cmp_value=req_period[sel].
  - If the period is nonzero: tmr_start=1, tmr_en=1, go to RUN.
  - If the period is 0: go to ZERO without starting the timer.
- Latency: req sampled at cycle T gives grant at T+1, with tmr_start at T+1.
- RUN:
  - tmr_en held 1, tmr_cmp_value held stable.
  - tmr_done at cycle T: at T+1, expired[owner]=1, tmr_en=0, busy=0, pointer=(owner+1) mod NUM_REQ, state IDLE.
- ZERO: next edge expired[owner]=1, pointer advanced, state IDLE.
- IDLE re-entry: the earliest next grant is one cycle after the expired pulse.
- Cancel in RUN:
  - cancel[owner] at T with no tmr_done: at T+1, tmr_en=0, busy=0, no expired pulse, pointer advanced, state IDLE.
  - cancel and tmr_done in the same cycle: done wins and expired is pulsed.
- cancel of a non-owner has no effect.
- cancel[i] together with req[i] in IDLE: requester i is masked from selection that cycle.
- tmr_done seen in IDLE or ZERO is ignored.
- Fairness: a requester holding req continuously is granted at most once per full pointer rotation while others are pending.
- grant and expired are never both nonzero in the same cycle; each is at most one-hot.
- busy = 1 in RUN and ZERO.

Optional Feature:
- Macro: TIMER_ARB_IRQ_EN.
- When defined, add these ports:
  - irq_status out NUM_REQ: sticky; bit i set on expired[i], cleared by irq_clr[i].
  - irq_clr in NUM_REQ: clear request per status bit.
  - irq out 1: OR of irq_status & irq_mask.
  - irq_mask in NUM_REQ: per-bit interrupt mask.
- Set and clear in the same cycle: set wins. Reset clears irq_status.
- When undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- NUM_REQ=4. Reset, then req=0001, period0=10, with a timer model asserting done 10 cycles after start -> grant=0001 next cycle, tmr_cmp_value=10, tmr_start pulse, expired=0001 one cycle after done, busy falls with it.
- req=1111 held, all periods 5 -> grant order 0,1,2,3,0; each grant exactly one cycle after the previous expired.
- req=0100, period2=0 -> grant=0100, expired=0100 on the following cycle, tmr_start never asserted.
- req1 granted with period 100; at cycle 20 cancel=0010 -> tmr_en=0 next cycle, no expired, pointer=2; a pending req3 is granted on the following cycle.
- cancel[owner] and tmr_done in the same cycle -> expired[owner] pulsed. rst asserted during RUN -> all outputs 0 next cycle, no expired.
- With TIMER_ARB_IRQ_EN and irq_mask=0001: expiry of req0 -> irq_status=0001, irq=1. irq_clr=0001 in the same cycle as a new expired[0] -> status stays 1.
